// File: rtl/key_event_decoder.sv
// -----------------------------------------------------------------------------
// key_event_decoder
//
// Turns one debounced key level into single-cycle UI events. A hold of the
// add key, for example, becomes press -> long -> repeat, repeat, ... -> release.
//
// Configuration macro:
//   KEY_REPEAT_EN  defined   : the LONG state emits repeat_pulse every
//                              REPEAT_TIME cycles.
//                  undefined : repeat_pulse is tied low and LONG only waits
//                              for the release.
//
// Ports:
//   clk            system clock
//   rst            asynchronous active-high reset
//   key_in         debounced key level, synchronous to clk
//   press_pulse    one cycle on each accepted press
//   short_pulse    one cycle on a release before LONG_TIME
//   long_pulse     one cycle when the hold reaches LONG_TIME
//   repeat_pulse   one cycle every REPEAT_TIME while in the long-press state
//   release_pulse  one cycle on every release of an accepted press
//   key_held       high while a press is being tracked (PRESS or LONG)
//
// Latency from a key_in change to its pulse is 3 clock edges:
// sample (s0), delay (s1 plus the registered edge flags), output register.
// -----------------------------------------------------------------------------
`default_nettype none

module key_event_decoder #(
  parameter int   LONG_TIME   = 50_000_000,
  parameter int   REPEAT_TIME = 10_000_000,
  parameter int   CNT_W       = 26,
  parameter logic ACTIVE_LOW  = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic press_pulse,
  output logic short_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic release_pulse,
  output logic key_held
);

  // Illegal configurations are rejected at elaboration.
  if (LONG_TIME < 2 || REPEAT_TIME < 2) begin : g_bad_time
    $error("key_event_decoder: LONG_TIME and REPEAT_TIME must both be >= 2");
  end
  if ((64'd1 << CNT_W) <= 64'(LONG_TIME) || (64'd1 << CNT_W) <= 64'(REPEAT_TIME)) begin : g_bad_width
    $error("key_event_decoder: CNT_W too small for LONG_TIME/REPEAT_TIME");
  end

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TIME - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRESS = 2'd1,
    ST_LONG  = 2'd2
  } state_t;

  // k = 1 means pressed regardless of the key polarity.
  logic k;
  assign k = key_in ^ ACTIVE_LOW;

  // Stage 0/1: sample and delay. Resetting both to "pressed" means a key held
  // through reset never looks like a new press; it has to be released first.
  logic s0;
  logic s1;
  logic rise_p2;
  logic fall_p2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0      <= 1'b1;
      s1      <= 1'b1;
      rise_p2 <= 1'b0;
      fall_p2 <= 1'b0;
    end else begin
      s0      <= k;
      s1      <= s0;
      rise_p2 <= s0 & ~s1;
      fall_p2 <= ~s0 & s1;
    end
  end

  // Stage 2: event FSM with registered outputs.
  state_t           state;
  state_t           state_d;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_d;
  logic             press_d;
  logic             short_d;
  logic             long_d;
  logic             release_d;

`ifdef KEY_REPEAT_EN
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TIME - 1);
  logic repeat_q;
  logic repeat_d;
  assign repeat_pulse = repeat_q;
`else
  assign repeat_pulse = 1'b0;
`endif

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    press_d   = 1'b0;
    short_d   = 1'b0;
    long_d    = 1'b0;
    release_d = 1'b0;
`ifdef KEY_REPEAT_EN
    repeat_d  = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        cnt_d = '0;
        if (rise_p2) begin
          state_d = ST_PRESS;
          press_d = 1'b1;
        end
      end
      ST_PRESS: begin
        // A release arriving on the threshold cycle counts as a short click.
        if (fall_p2) begin
          short_d   = 1'b1;
          release_d = 1'b1;
          state_d   = ST_IDLE;
          cnt_d     = '0;
        end else if (cnt == LONG_LAST) begin
          long_d  = 1'b1;
          cnt_d   = '0;
          state_d = ST_LONG;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      ST_LONG: begin
        // A release on the repeat threshold suppresses that repeat.
        if (fall_p2) begin
          release_d = 1'b1;
          state_d   = ST_IDLE;
          cnt_d     = '0;
        end else begin
`ifdef KEY_REPEAT_EN
          if (cnt == REPEAT_LAST) begin
            repeat_d = 1'b1;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt + 1'b1;
          end
`else
          cnt_d = '0;
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      press_pulse   <= 1'b0;
      short_pulse   <= 1'b0;
      long_pulse    <= 1'b0;
      release_pulse <= 1'b0;
      key_held      <= 1'b0;
`ifdef KEY_REPEAT_EN
      repeat_q      <= 1'b0;
`endif
    end else begin
      state         <= state_d;
      cnt           <= cnt_d;
      press_pulse   <= press_d;
      short_pulse   <= short_d;
      long_pulse    <= long_d;
      release_pulse <= release_d;
      key_held      <= (state_d != ST_IDLE);
`ifdef KEY_REPEAT_EN
      repeat_q      <= repeat_d;
`endif
    end
  end

endmodule

`default_nettype wire
